// File: rtl/bus_sequencer.sv
// Step-timing controller for the shared 32-bit datapath bus.
// Walks one register-register ALU instruction through T0..T5, driving the
// one-hot bus source select and every register load enable. The T1 memory
// read is bounded by a wait counter so a dead memory aborts back to IDLE.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nothing driven, waiting for start
// T0    | PC onto bus, load MAR, Z <= PC+1
// T1    | memory read; PC <= Zlow on first cycle, MDR on mem_done
// T2    | MDR onto bus, load IR
// T3    | rb onto bus, load Y
// T4    | rc onto bus, Z <= Y op rc
// T5    | Zlow onto bus, write ra, done; start chains directly into T0
module bus_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        mem_done,
  output logic [31:0] bus_sel,
  output logic [15:0] reg_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        inc_pc,
  output logic        mem_read,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6
  } state_e;

  localparam logic [31:0] SEL_ZLOW = 32'h0008_0000;
  localparam logic [31:0] SEL_PC   = 32'h0010_0000;
  localparam logic [31:0] SEL_MDR  = 32'h0020_0000;
  localparam logic [4:0]  ALU_ADD  = 5'b00011;

  // Wait count value on the last T1 cycle allowed before aborting, so T1
  // never lasts more than MEM_TIMEOUT cycles.
  localparam logic [7:0]  LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;

  // Only the opcode and register fields matter here; the immediate bits are
  // consumed elsewhere in the datapath.
  logic       unused_ir;
  assign unused_ir = ^ir[14:0];

  // State, T1 wait counter and timeout pulse registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and Moore output decode (mdr_in follows mem_done in T1).
  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    err_d    = 1'b0;
    bus_sel  = '0;
    reg_in   = '0;
    pc_in    = 1'b0;
    ir_in    = 1'b0;
    mar_in   = 1'b0;
    mdr_in   = 1'b0;
    y_in     = 1'b0;
    z_in     = 1'b0;
    inc_pc   = 1'b0;
    mem_read = 1'b0;
    alu_op   = '0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_T0;
      end
      S_T0: begin
        bus_sel = SEL_PC;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        z_in    = 1'b1;
        alu_op  = ALU_ADD;
        state_d = S_T1;
      end
      S_T1: begin
        mem_read = 1'b1;
        bus_sel  = SEL_ZLOW;
        pc_in    = (wait_q == 8'd0);
        mdr_in   = mem_done;
        if (mem_done) begin
          state_d = S_T2;
        end else if (wait_q == LAST_WAIT) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
      end
      S_T2: begin
        bus_sel = SEL_MDR;
        ir_in   = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        bus_sel = 32'd1 << ir[22:19];
        y_in    = 1'b1;
        state_d = S_T4;
      end
      S_T4: begin
        bus_sel = 32'd1 << ir[18:15];
        z_in    = 1'b1;
        alu_op  = ir[31:27];
        state_d = S_T5;
      end
      S_T5: begin
        bus_sel = SEL_ZLOW;
        reg_in  = 16'd1 << ir[26:23];
        done    = 1'b1;
        state_d = start ? S_T0 : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: each instruction is expanded into its expected
// per-cycle output trace from the instruction-level rules (six steps, T1
// stretched by the memory latency, abort after TO cycles of T1) and compared
// cycle by cycle, together with a one-hot invariant check.
module tb_bus_sequencer;

  localparam int TO = 4;

  localparam int F_PC   = 10;
  localparam int F_IR   = 9;
  localparam int F_MAR  = 8;
  localparam int F_MDR  = 7;
  localparam int F_Y    = 6;
  localparam int F_Z    = 5;
  localparam int F_INC  = 4;
  localparam int F_MRD  = 3;
  localparam int F_BUSY = 2;
  localparam int F_DONE = 1;
  localparam int F_ERR  = 0;

  logic        clock = 1'b0;
  logic        clear, start, mem_done;
  logic [31:0] ir;
  logic [31:0] bus_sel;
  logic [15:0] reg_in;
  logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, inc_pc, mem_read;
  logic [4:0]  alu_op;
  logic        busy, done, err;

  int n_chk  = 0;
  int n_pass = 0;

  bus_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .mem_done(mem_done),
    .bus_sel(bus_sel), .reg_in(reg_in), .pc_in(pc_in), .ir_in(ir_in),
    .mar_in(mar_in), .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in),
    .inc_pc(inc_pc), .mem_read(mem_read), .alu_op(alu_op),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [63:0] ev(input logic [31:0] bs, input logic [15:0] ri,
                                     input logic [4:0] al, input logic [10:0] fl);
    return {bs, ri, al, fl};
  endfunction

  function automatic logic [63:0] observed();
    return {bus_sel, reg_in, alu_op, pc_in, ir_in, mar_in, mdr_in, y_in, z_in,
            inc_pc, mem_read, busy, done, err};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected vectors per instruction step.
  function automatic logic [63:0] e_idle(input logic e);
    logic [10:0] f = '0;
    f[F_ERR] = e;
    return ev('0, '0, '0, f);
  endfunction

  function automatic logic [63:0] e_t0();
    logic [10:0] f = '0;
    f[F_MAR] = 1; f[F_INC] = 1; f[F_Z] = 1; f[F_BUSY] = 1;
    return ev(32'h1 << 20, '0, 5'd3, f);
  endfunction

  function automatic logic [63:0] e_t1(input logic first, input logic md);
    logic [10:0] f = '0;
    f[F_MRD] = 1; f[F_BUSY] = 1; f[F_PC] = first; f[F_MDR] = md;
    return ev(32'h1 << 19, '0, '0, f);
  endfunction

  function automatic logic [63:0] e_t2();
    logic [10:0] f = '0;
    f[F_IR] = 1; f[F_BUSY] = 1;
    return ev(32'h1 << 21, '0, '0, f);
  endfunction

  function automatic logic [63:0] e_t3(input logic [31:0] iv);
    logic [10:0] f = '0;
    f[F_Y] = 1; f[F_BUSY] = 1;
    return ev(32'h1 << iv[22:19], '0, '0, f);
  endfunction

  function automatic logic [63:0] e_t4(input logic [31:0] iv);
    logic [10:0] f = '0;
    f[F_Z] = 1; f[F_BUSY] = 1;
    return ev(32'h1 << iv[18:15], '0, iv[31:27], f);
  endfunction

  function automatic logic [63:0] e_t5(input logic [31:0] iv);
    logic [10:0] f = '0;
    f[F_DONE] = 1; f[F_BUSY] = 1;
    return ev(32'h1 << 19, 16'h1 << iv[26:23], '0, f);
  endfunction

  // One clock cycle: apply inputs, compare outputs mid-cycle, advance.
  task automatic cyc(input string tag, input logic clr, input logic st,
                     input logic md, input logic [63:0] exp);
    logic ok;
    clear = clr; start = st; mem_done = md;
    #1;
    check(tag, observed(), exp);
    ok = ($countones(bus_sel) <= 1) && ($countones(reg_in) <= 1) && (bus_sel[31:24] == 8'h00);
    check({tag, "_onehot"}, {63'b0, ok}, 64'd1);
    @(posedge clock);
    #1;
  endtask

  // One instruction starting in T0; w = cycles mem_done stays low in T1.
  task automatic instr(input logic [31:0] iv, input int w, input logic st_next,
                       input bit noise, output bit timed_out);
    timed_out = 0;
    ir = iv;
    cyc("T0", 0, noise ? rb() : 1'b0, noise ? rb() : 1'b0, e_t0());
    for (int k = 0; k < TO; k++) begin
      if (k == w) begin
        cyc("T1_ack", 0, noise ? rb() : 1'b0, 1'b1, e_t1(k == 0, 1'b1));
        break;
      end else begin
        cyc("T1_wait", 0, noise ? rb() : 1'b0, 1'b0, e_t1(k == 0, 1'b0));
        if (k == TO - 1) timed_out = 1;
      end
    end
    if (timed_out) begin
      cyc("err_pulse", 0, 1'b0, noise ? rb() : 1'b0, e_idle(1'b1));
      return;
    end
    cyc("T2", 0, noise ? rb() : 1'b0, noise ? rb() : 1'b0, e_t2());
    cyc("T3", 0, noise ? rb() : 1'b0, noise ? rb() : 1'b0, e_t3(iv));
    cyc("T4", 0, noise ? rb() : 1'b0, noise ? rb() : 1'b0, e_t4(iv));
    cyc("T5", 0, st_next, noise ? rb() : 1'b0, e_t5(iv));
  endtask

  initial begin
    bit to;
    bit running;
    logic [31:0] iv;
    int w, r;

    clear = 1; start = 0; mem_done = 0; ir = '0;
    repeat (2) @(posedge clock);
    #1;
    cyc("reset_state", 0, 0, 0, e_idle(1'b0));
    cyc("idle_hold", 0, 0, 1, e_idle(1'b0));

    // Single instruction, memory answers on first T1 cycle.
    ir = 32'h1A18_0000;
    cyc("go_single", 0, 1, 0, e_idle(1'b0));
    instr(32'h1A18_0000, 0, 1'b0, 0, to);
    cyc("after_single", 0, 0, 0, e_idle(1'b0));

    // Memory wait: three low cycles, ack on the 4th (also the last legal T1 cycle).
    cyc("go_wait", 0, 1, 0, e_idle(1'b0));
    instr(32'h2C9A_8000, 3, 1'b0, 0, to);
    check("wait_no_timeout", {63'b0, to}, 64'd0);
    cyc("after_wait", 0, 0, 0, e_idle(1'b0));

    // Timeout: mem_done never comes.
    cyc("go_timeout", 0, 1, 0, e_idle(1'b0));
    instr(32'h0F0F_0F0F, 100, 1'b0, 0, to);
    cyc("err_single", 0, 0, 0, e_idle(1'b0));

    // Back-to-back with start held high.
    cyc("go_b2b", 0, 1, 0, e_idle(1'b0));
    instr(32'h1A18_0000, 0, 1'b1, 0, to);
    instr(32'h8123_4567, 0, 1'b1, 0, to);
    instr(32'hFFFF_FFFF, 0, 1'b1, 0, to);
    instr(32'h0000_0000, 0, 1'b0, 0, to);
    cyc("after_b2b", 0, 0, 0, e_idle(1'b0));

    // Clear held two cycles starting in T3.
    ir = 32'h1A18_0000;
    cyc("go_clr", 0, 1, 0, e_idle(1'b0));
    cyc("clr_T0", 0, 0, 0, e_t0());
    cyc("clr_T1", 0, 0, 1, e_t1(1'b1, 1'b1));
    cyc("clr_T2", 0, 0, 0, e_t2());
    cyc("clr_T3", 1, 0, 0, e_t3(ir));
    cyc("clr_idle1", 1, 1, 0, e_idle(1'b0));
    cyc("clr_idle2", 0, 0, 0, e_idle(1'b0));

    // Clear on the timeout cycle suppresses err.
    cyc("go_clr_to", 0, 1, 0, e_idle(1'b0));
    cyc("clrto_T0", 0, 0, 0, e_t0());
    for (int k = 0; k < TO - 1; k++)
      cyc("clrto_T1", 0, 0, 0, e_t1(k == 0, 1'b0));
    cyc("clrto_last", 1, 0, 0, e_t1(1'b0, 1'b0));
    cyc("clrto_no_err", 0, 0, 0, e_idle(1'b0));

    // Randomized instruction stream.
    running = 0;
    for (int i = 0; i < 200; i++) begin
      iv = $urandom;
      r  = $urandom_range(0, 9);
      if (r < 6)      w = 0;
      else if (r < 8) w = $urandom_range(1, TO - 1);
      else            w = $urandom_range(TO, TO + 3);
      if (!running) begin
        repeat ($urandom_range(0, 2)) cyc("rnd_idle", 0, 0, rb(), e_idle(1'b0));
        cyc("rnd_go", 0, 1, rb(), e_idle(1'b0));
      end
      instr(iv, w, rb(), 1, to);
      running = (dut_chain(to));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Last T5 start decides chaining; a timed-out instruction always lands in IDLE.
  logic last_t5_start;
  always @(posedge clock) if (done) last_t5_start <= start;

  function automatic bit dut_chain(input bit to);
    return !to && (last_t5_start === 1'b1);
  endfunction

endmodule
